// File: rtl/imem_stream_loader_if.sv
// Byte-stream in / instruction-memory write port out, bundled for imem_stream_loader.
// slave = the loader, master = the stream source and memory side.
interface imem_stream_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 48
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                     i_start;
  logic                     i_valid;
  logic [7:0]               i_data;
  logic                     o_ready;
  logic                     o_mea;
  logic [LANES-1:0]         o_wea;
  logic [ADDRESS_WIDTH-1:0] o_adra;
  logic [DATA_WIDTH-1:0]    o_da;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_err;

  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_mea, o_wea, o_adra, o_da, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_mea, o_wea, o_adra, o_da, o_busy, o_done, o_err
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Packs a length-prefixed byte stream into instruction words on the imem write port.
// Optional IMEM_LOADER_CHECKSUM_EN: trailing XOR checksum byte after the payload.
module imem_stream_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 48,
  parameter int BASE_ADDR     = 0,
  parameter int MAX_BYTES     = 6144
) (
  input  logic                i_clk,
  input  logic                i_rst,
  imem_stream_loader_if.slave bus
);
  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_len;
  logic [1:0]               r_hdr;
  logic [31:0]              r_cnt;
  logic [LANE_W-1:0]        r_lane;
  logic [ADDRESS_WIDTH-1:0] r_adra;
  logic [DATA_WIDTH-1:0]    r_da;
  logic [LANES-1:0]         r_wea;
  logic                     r_mea;
  logic                     r_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]               r_csum;
`endif

  logic        w_accept;
  logic [31:0] w_len_next;
  logic        w_last_byte;
  logic        w_lane_full;

  assign w_accept    = bus.i_valid && r_ready;
  assign w_len_next  = {bus.i_data, r_len[31:8]};
  assign w_last_byte = ((r_cnt + 32'd1) == r_len);
  assign w_lane_full = (r_lane == LANE_W'(LANES - 1));

  assign bus.o_ready = r_ready;
  assign bus.o_mea   = r_mea;
  assign bus.o_wea   = r_wea;
  assign bus.o_adra  = r_adra;
  assign bus.o_da    = r_da;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_err   = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_hdr   <= '0;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_adra  <= ADDRESS_WIDTH'(BASE_ADDR);
      r_da    <= '0;
      r_wea   <= '0;
      r_mea   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            r_state <= S_LEN;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_len   <= '0;
            r_hdr   <= '0;
            r_cnt   <= '0;
            r_lane  <= '0;
            r_adra  <= ADDRESS_WIDTH'(BASE_ADDR);
            r_da    <= '0;
            r_wea   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end

        S_LEN: begin
          if (w_accept) begin
            r_len <= w_len_next;
            r_hdr <= r_hdr + 2'd1;
            if (r_hdr == 2'd3) begin
              if (w_len_next == 32'd0 || w_len_next > 32'(MAX_BYTES)) begin
                r_err   <= (w_len_next != 32'd0);
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            for (int k = 0; k < LANES; k++) begin
              if (r_lane == LANE_W'(k)) begin
                r_da[k*8 +: 8] <= bus.i_data;
                r_wea[k]       <= 1'b1;
              end
            end
            r_lane <= r_lane + LANE_W'(1);
            r_cnt  <= r_cnt + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ bus.i_data;
`endif
            if (w_lane_full || w_last_byte) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_mea   <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          r_mea  <= 1'b0;
          r_da   <= '0;
          r_wea  <= '0;
          r_lane <= '0;
          r_adra <= r_adra + ADDRESS_WIDTH'(LANES);
          if (r_cnt != r_len) begin
            r_state <= S_DATA;
            r_ready <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state <= S_CSUM;
            r_ready <= 1'b1;
`else
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            if (bus.i_data != r_csum) r_err <= 1'b1;
            r_state <= S_DONE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_mea   <= 1'b0;
        end
      endcase
    end
  end
endmodule
